// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional even/odd parity,
// 1 or 2 stop bits, oversampled bit timing and a valid/ready input handshake.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_reg,    state_next;
  logic [TICK_W-1:0]      tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]       bit_cnt_reg,  bit_cnt_next;
  logic [STOP_W-1:0]      stop_cnt_reg, stop_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg,    shift_next;
  logic                   parity_reg,   parity_next;
  logic                   tx_reg,       tx_next;
  logic                   ready_reg,    ready_next;
  logic                   busy_reg,     busy_next;
  logic                   done_reg,     done_next;
  logic                   bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Last tick of the current bit period: every state transition happens here.
  assign bit_end = b_tick && (tick_cnt_reg == TICK_LAST);

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    ready_next    = ready_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    if (state_reg != IDLE && b_tick) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + TICK_W'(1);
    end

    case (state_reg)
      IDLE: begin
        // b_tick is ignored here and on the accept edge itself
        if (tx_valid && ready_reg) begin
          shift_next    = tx_data;
          parity_next   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          tx_next       = 1'b0;
          ready_next    = 1'b0;
          busy_next     = 1'b1;
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          stop_cnt_next = '0;
          state_next    = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_reg == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_next    = parity_reg;
              state_next = PARITY;
            end else begin
              tx_next       = 1'b1;
              stop_cnt_next = '0;
              state_next    = STOP;
            end
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          tx_next       = 1'b1;
          stop_cnt_next = '0;
          state_next    = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == STOP_LAST) begin
            tx_next    = 1'b1;
            ready_next = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + STOP_W'(1);
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign tx_ready = ready_reg;
  assign tx_busy  = busy_reg;
  assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) decoded by a
// mid-bit sampling receiver model and checked against a frame scoreboard.
module tb_uart_tx_cfg;

  function automatic int cfg_db(int i); return (i == 3) ? 7 : 8; endfunction
  function automatic int cfg_pe(int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int i); return (i == 3) ? 2 : 1; endfunction
  function automatic int cfg_nbits(int i);
    return 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
  endfunction

  // Expected line bits, index 0 = start bit, unused upper bits zero
  function automatic logic [15:0] exp_frame(int i, logic [8:0] w);
    logic [15:0] f = '0;
    logic        p = 1'b0;
    int          k;
    for (int b = 0; b < cfg_db(i); b++) begin
      f[1+b] = w[b];
      p      = p ^ w[b];
    end
    k = 1 + cfg_db(i);
    if (cfg_pe(i) != 0) begin
      f[k] = (cfg_po(i) != 0) ? ~p : p;
      k++;
    end
    for (int s = 0; s < cfg_sb(i); s++) f[k+s] = 1'b1;
    return f;
  endfunction

  typedef struct {
    int          inst;
    logic [15:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_tick = 1'b1;
  logic       valid_r [4];
  logic [8:0] data_r  [4];
  logic       tx_w    [4];
  logic       ready_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   tick_div = 1;
  bit   len_chk = 1'b1;
  bit   gap_chk = 1'b0;
  int   acc_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt [4] = '{default: 0};
  int   exp_done [4] = '{default: 0};
  int   overlap = 0;
  exp_t sb[$];

  int          m_st   [4] = '{default: 0};
  int          m_tc   [4] = '{default: 0};
  int          m_bi   [4] = '{default: 0};
  logic [15:0] m_bits [4];
  int          n_tr = 0;
  int          last_tr = 0;
  logic        prev_tx = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    b_tick = (tick_div <= 1) ? 1'b1 : ((cyc % tick_div) == 0);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int DB = cfg_db(gi);
    uart_tx_cfg #(
      .DATA_BITS (DB),
      .PARITY_EN (cfg_pe(gi)),
      .PARITY_ODD(cfg_po(gi)),
      .STOP_BITS (cfg_sb(gi)),
      .OVERSAMPLE(16)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .b_tick  (b_tick),
      .tx_valid(valid_r[gi]),
      .tx_data (data_r[gi][DB-1:0]),
      .tx_ready(ready_w[gi]),
      .tx_busy (busy_w[gi]),
      .tx_done (done_w[gi]),
      .tx      (tx_w[gi])
    );
  end

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model, done/idle checks and bit-period gap measurement
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (busy_w[i] && ready_w[i]) overlap++;
      if (rst) begin
        m_st[i] = 0;
      end else if (m_st[i] == 0 && tx_w[i] == 1'b0) begin
        m_st[i]   = 1;
        m_tc[i]   = 0;
        m_bi[i]   = 0;
        m_bits[i] = '0;
      end
      if (!rst && m_st[i] == 1 && b_tick) begin
        m_tc[i]++;
        if (m_tc[i] == m_bi[i] * 16 + 8) begin
          m_bits[i][m_bi[i]] = tx_w[i];
          m_bi[i]++;
          if (m_bi[i] == cfg_nbits(i)) begin
            m_st[i] = 0;
            if (sb.size() == 0) begin
              check("sb_underflow", 1, 0);
            end else begin
              e = sb.pop_front();
              $display("rx inst %0d frame 0x%04h expected 0x%04h", i, m_bits[i], e.frame);
              check("frame_bits", int'(m_bits[i]), int'(e.frame));
              check("frame_inst", i, e.inst);
            end
          end
        end
      end
      if (done_w[i]) begin
        done_cnt[i]++;
        done_cyc = cyc;
        if (len_chk) check("frame_len", cyc - acc_cyc, 16 * cfg_nbits(i));
        check("done_tx_high", int'(tx_w[i]), 1);
        check("done_ready", int'(ready_w[i]), 1);
        check("done_busy", int'(busy_w[i]), 0);
      end
    end
    if (gap_chk && tx_w[0] !== prev_tx) begin
      if (n_tr >= 2) check("bit_period", cyc - last_tr, 64);
      n_tr++;
      last_tr = cyc;
      prev_tx = tx_w[0];
    end
  end

  task automatic send(int i, logic [8:0] w, bit push);
    int   n = 0;
    logic rdy;
    valid_r[i] = 1'b1;
    data_r[i]  = w;
    do begin
      rdy = ready_w[i];
      tick();
      n++;
    end while (!rdy && n < 1000);
    valid_r[i] = 1'b0;
    if (!rdy) check("accept_timeout", 0, 1);
    acc_cyc = cyc;
    if (push) begin
      sb.push_back('{i, exp_frame(i, w)});
      exp_done[i]++;
    end
    $display("tx inst %0d word 0x%03h accepted at cycle %0d", i, w, cyc);
  endtask

  task automatic wait_done(int i);
    int n = 0;
    while (done_cnt[i] < exp_done[i] && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt[i] < exp_done[i]) check("done_timeout", done_cnt[i], exp_done[i]);
    repeat (3) tick();
  endtask

  initial begin
    int   n;
    logic rdy;
    int   a2;
    for (int i = 0; i < 4; i++) begin
      valid_r[i] = 1'b0;
      data_r[i]  = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", int'(tx_w[i]), 1);
      check("rst_ready", int'(ready_w[i]), 1);
      check("rst_busy", int'(busy_w[i]), 0);
      check("rst_done", int'(done_w[i]), 0);
    end
    rst = 1'b0;
    tick();

    // Basic frames across every configuration
    send(0, 9'h055, 1'b1); wait_done(0);
    send(1, 9'h0A5, 1'b1); wait_done(1);
    send(2, 9'h0A5, 1'b1); wait_done(2);
    send(3, 9'h07F, 1'b1); wait_done(3);
    for (int r = 0; r < 3; r++) begin
      send(2, 9'($urandom_range(0, 255)), 1'b1); wait_done(2);
      send(3, 9'($urandom_range(0, 127)), 1'b1); wait_done(3);
    end

    // Back-to-back with tx_valid held high
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h012;
    n = 0;
    do begin rdy = ready_w[0]; tick(); n++; end while (!rdy && n < 100);
    acc_cyc = cyc;
    sb.push_back('{0, exp_frame(0, 9'h012)});
    data_r[0] = 9'h034;
    n = 0;
    do begin rdy = ready_w[0]; tick(); n++; end while (!rdy && n < 400);
    if (!rdy) check("b2b_accept_timeout", 0, 1);
    a2      = cyc;
    acc_cyc = a2;
    sb.push_back('{0, exp_frame(0, 9'h034)});
    valid_r[0] = 1'b0;
    $display("tx inst 0 back-to-back 0x012/0x034 second accept at cycle %0d", a2);
    check("b2b_idle_gap", a2 - done_cyc, 1);
    exp_done[0] += 2;
    wait_done(0);

    // Reset in the middle of a frame
    send(0, 9'h0AA, 1'b0);
    repeat (49) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", int'(tx_w[0]), 1);
    check("midrst_ready", int'(ready_w[0]), 1);
    check("midrst_busy", int'(busy_w[0]), 0);
    rst = 1'b0;
    repeat (200) tick();
    check("midrst_no_done", done_cnt[0], exp_done[0]);
    send(0, 9'h03C, 1'b1); wait_done(0);

    // Slow tick, input changed while busy
    tick_div = 4;
    len_chk  = 1'b0;
    n_tr     = 0;
    prev_tx  = 1'b1;
    gap_chk  = 1'b1;
    send(0, 9'h055, 1'b1);
    repeat (20) tick();
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h0FF;
    repeat (100) tick();
    check("busy_ready_low", int'(ready_w[0]), 0);
    valid_r[0] = 1'b0;
    wait_done(0);
    gap_chk = 1'b0;
    check("transitions", n_tr, 10);
    tick_div = 1;
    len_chk  = 1'b1;

    for (int i = 0; i < 4; i++) check("done_count", done_cnt[i], exp_done[i]);
    check("sb_empty", sb.size(), 0);
    check("ready_busy_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
